// File: rtl/memory_ram_dual_pkg.sv
// rtl/memory_ram_dual_pkg.sv - shared j2 widths and clear-sequencer state encodings
package memory_ram_dual_pkg;

   localparam int J2_WORD_WIDTH = 16;
   localparam int J2_ADDR_WIDTH = 13;

   localparam logic [0:0] STATE_CLEAR = 1'b0;
   localparam logic [0:0] STATE_READY = 1'b1;

endpackage

// File: rtl/memory_ram_clear_ctrl.sv
// rtl/memory_ram_clear_ctrl.sv - CLEAR/READY state machine and array sweep counter
module memory_ram_clear_ctrl
   import memory_ram_dual_pkg::*;
#(
   parameter int DEPTH          = 32,
   parameter int CLEAR_ON_RESET = 1,
   localparam int CNT_W         = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   output logic             ready,
   output logic             clear_we,
   output logic [CNT_W-1:0] clear_address
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

   logic [0:0]       state;
   logic [CNT_W-1:0] counter;

   // Without clearing, CLEAR lasts exactly one edge after reset release.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= STATE_CLEAR;
         counter <= '0;
      end else if (state == STATE_CLEAR) begin
         if (CLEAR_ON_RESET == 0 || counter == LAST) begin
            state <= STATE_READY;
         end
         counter <= counter + 1'b1;
      end
   end

   assign ready         = (state == STATE_READY);
   assign clear_we      = (state == STATE_CLEAR) && (CLEAR_ON_RESET != 0);
   assign clear_address = counter;

endmodule

// File: rtl/memory_ram_dual.sv
// rtl/memory_ram_dual.sv - j2 dual-port RAM: read-only code port, read/write data port
// Option macro MEMORY_RAM_CODE_BYPASS_EN: forward same-cycle data writes onto the code port.
module memory_ram_dual
   import memory_ram_dual_pkg::*;
#(
   parameter int DATA_WIDTH     = J2_WORD_WIDTH,
   parameter int ADDR_WIDTH     = J2_ADDR_WIDTH,
   parameter int DEPTH          = 32,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] code_address,
   output logic [DATA_WIDTH-1:0] code_value,
   input  logic [ADDR_WIDTH-1:0] data_address,
   input  logic                  data_write_enable,
   input  logic [DATA_WIDTH-1:0] data_write_value,
   output logic [DATA_WIDTH-1:0] data_read_value,
   output logic                  ready,
   output logic                  collision
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

   if (DEPTH < 2 || 64'(DEPTH) > (64'd1 << ADDR_WIDTH)) begin : g_bad_depth
      $error("memory_ram_dual: DEPTH must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic             clear_we;
   logic [IDX_W-1:0] clear_address;

   memory_ram_clear_ctrl #(
      .DEPTH          (DEPTH),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clear_ctrl (
      .clock         (clock),
      .reset_n       (reset_n),
      .ready         (ready),
      .clear_we      (clear_we),
      .clear_address (clear_address)
   );

   logic             code_in_range;
   logic             data_in_range;
   logic             user_we;
   logic             same_address;
   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [IDX_W-1:0] code_idx;
   logic [IDX_W-1:0] data_idx;

   assign code_in_range = ({1'b0, code_address} < DEPTH_A);
   assign data_in_range = ({1'b0, data_address} < DEPTH_A);
   assign code_idx      = code_address[IDX_W-1:0];
   assign data_idx      = data_address[IDX_W-1:0];
   assign user_we       = ready && data_write_enable && data_in_range;
   assign same_address  = (data_address == code_address);

   // The sweep owns the write port while clearing; user writes need ready.
   assign wr_en   = clear_we || user_we;
   assign wr_idx  = clear_we ? clear_address : data_idx;
   assign wr_data = clear_we ? '0 : data_write_value;

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         code_value <= '0;
      end else if (!ready || !code_in_range) begin
         code_value <= '0;
`ifdef MEMORY_RAM_CODE_BYPASS_EN
      end else if (user_we && same_address) begin
         code_value <= data_write_value;
`endif
      end else begin
         code_value <= mem[code_idx];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_read_value <= '0;
      end else if (!ready || !data_in_range) begin
         data_read_value <= '0;
      end else begin
         data_read_value <= mem[data_idx];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         collision <= 1'b0;
      end else begin
         collision <= user_we && same_address;
      end
   end

endmodule
